// File: rtl/key_entry_buffer.sv
// Debounced calculator keypad front end: one key event per press, accumulated
// into a BCD operand that is handed off with its operator over a valid/ack pair.
module key_entry_buffer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [3:0]              BCDKey,
  input  logic                    KeyRead,
  input  logic                    EntryAck,
  output logic [4*NUM_DIGITS-1:0] Operand,
  output logic [2:0]              DigitCount,
  output logic [3:0]              OpCode,
  output logic                    EntryValid,
  output logic                    Overflow,
  output logic [1:0]              dbg_state
);

  // Handshake: EntryValid rises with a completed entry and holds Operand/OpCode
  // stable; the entry is consumed in any cycle where EntryAck is high with it.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [8:0] DB_LIM    = 9'(DEBOUNCE_CYCLES);
  localparam logic [2:0] MAX_COUNT = 3'(NUM_DIGITS);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [3:0]              cand_q, cand_d;
  logic [4*NUM_DIGITS-1:0] operand_q, operand_d;
  logic [2:0]              count_q, count_d;
  logic [3:0]              opcode_q, opcode_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    key_accept;
  logic [8:0]              cnt_inc;
  logic                    is_digit;
  logic                    is_oper;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (KeyRead) begin
          state_d = PRESS_DB;
          cand_d  = BCDKey;
          cnt_d   = 8'd1;
        end
      end
      PRESS_DB: begin
        if (!KeyRead || (BCDKey != cand_q)) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_inc >= DB_LIM) begin
          key_accept = 1'b1;
          state_d    = HELD;
          cnt_d      = 8'd0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      HELD: begin
        if (!KeyRead) begin
          state_d = RELEASE_DB;
          cnt_d   = 8'd1;
        end
      end
      RELEASE_DB: begin
        if (KeyRead) begin
          state_d = HELD;
          cnt_d   = 8'd0;
        end else if (cnt_inc >= DB_LIM) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign is_digit = (cand_q <= 4'h9);
  assign is_oper  = (cand_q == 4'hA) || (cand_q == 4'hB) ||
                    (cand_q == 4'hC) || (cand_q == 4'hE);

  // Clear outranks the acknowledge; a pending entry blocks every other key.
  always_comb begin
    operand_d  = operand_q;
    count_d    = count_q;
    opcode_d   = opcode_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (key_accept && (cand_q == 4'hD)) begin
      operand_d = '0;
      count_d   = 3'd0;
      opcode_d  = 4'h0;
      valid_d   = 1'b0;
    end else if (valid_q) begin
      if (EntryAck) begin
        valid_d   = 1'b0;
        operand_d = '0;
        count_d   = 3'd0;
      end
    end else if (key_accept) begin
      if (is_digit) begin
        if (count_q < MAX_COUNT) begin
          operand_d[3:0] = cand_q;
          for (int i = 1; i < NUM_DIGITS; i++) begin
            operand_d[4*i +: 4] = operand_q[4*(i-1) +: 4];
          end
          count_d = count_q + 3'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (cand_q == 4'hF) begin
        if (count_q != 3'd0) begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            operand_d[4*i +: 4] = operand_q[4*(i+1) +: 4];
          end
          operand_d[4*NUM_DIGITS-4 +: 4] = 4'h0;
          count_d = count_q - 3'd1;
        end
      end else if (is_oper) begin
        opcode_d = cand_q;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      cand_q     <= 4'h0;
      operand_q  <= '0;
      count_q    <= 3'd0;
      opcode_q   <= 4'h0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      operand_q  <= operand_d;
      count_q    <= count_d;
      opcode_q   <= opcode_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign Operand    = operand_q;
  assign DigitCount = count_q;
  assign OpCode     = opcode_q;
  assign EntryValid = valid_q;
  assign Overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: directed scenarios plus random key traffic, all
// checked each cycle against a run-length/queue-free behavioural model.
module tb_key_entry_buffer;

  localparam int D = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bcd_key = 4'h0;
  logic        key_read = 1'b0;
  logic        entry_ack = 1'b0;
  logic [15:0] operand;
  logic [2:0]  digit_count;
  logic [3:0]  op_code;
  logic        entry_valid;
  logic        overflow;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int ovf_seen = 0;

  // behavioural model state
  int          press_run = 0;
  int          rel_run = 0;
  bit          held = 0;
  logic [3:0]  cand = 4'h0;
  logic [15:0] m_operand = 16'h0;
  int          m_count = 0;
  logic [3:0]  m_op = 4'h0;
  bit          m_valid = 0;
  bit          m_ovf = 0;

  key_entry_buffer #(.DEBOUNCE_CYCLES(D), .NUM_DIGITS(N)) dut (
    .CLK(clk), .RESET(rst), .BCDKey(bcd_key), .KeyRead(key_read),
    .EntryAck(entry_ack), .Operand(operand), .DigitCount(digit_count),
    .OpCode(op_code), .EntryValid(entry_valid), .Overflow(overflow),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A key counts once it has been seen with the same code for D consecutive
  // cycles; it must then be absent for D consecutive cycles before the next.
  task automatic model_update();
    bit acc;
    bit novf;
    acc = 0;
    novf = 0;
    if (rst) begin
      press_run = 0; rel_run = 0; held = 0;
      m_operand = 16'h0; m_count = 0; m_op = 4'h0; m_valid = 0; m_ovf = 0;
      return;
    end
    if (!held) begin
      if (press_run == 0) begin
        if (key_read) begin press_run = 1; cand = bcd_key; end
      end else if (!key_read || bcd_key != cand) begin
        press_run = 0;
      end else begin
        press_run++;
        if (press_run == D) begin acc = 1; held = 1; press_run = 0; rel_run = 0; end
      end
    end else begin
      if (rel_run == 0) begin
        if (!key_read) rel_run = 1;
      end else if (key_read) begin
        rel_run = 0;
      end else begin
        rel_run++;
        if (rel_run == D) begin held = 0; rel_run = 0; end
      end
    end
    if (acc && cand == 4'hD) begin
      m_operand = 16'h0; m_count = 0; m_op = 4'h0; m_valid = 0;
    end else if (m_valid) begin
      if (entry_ack) begin m_valid = 0; m_operand = 16'h0; m_count = 0; end
    end else if (acc) begin
      if (cand <= 4'h9) begin
        if (m_count < N) begin
          m_operand = (m_operand << 4) | {12'h0, cand};
          m_count++;
        end else novf = 1;
      end else if (cand == 4'hF) begin
        if (m_count > 0) begin m_operand = m_operand >> 4; m_count--; end
      end else if (cand != 4'hD) begin
        m_op = cand; m_valid = 1;
      end
    end
    m_ovf = novf;
  endtask

  task automatic compare();
    check("operand", 32'(operand), 32'(m_operand));
    check("digit_count", 32'(digit_count), 32'(m_count));
    check("op_code", 32'(op_code), 32'(m_op));
    check("entry_valid", 32'(entry_valid), 32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1;
      if (overflow) ovf_seen++;
      compare();
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    bcd_key = k;
    key_read = 1'b1;
    tick(hold);
    key_read = 1'b0;
    tick(rel);
  endtask

  task automatic ack_pulse();
    entry_ack = 1'b1;
    tick(1);
    entry_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_operand", 32'(operand), 32'h0);
    check("reset_valid", 32'(entry_valid), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);

    // one long press gives exactly one digit
    press(4'h7, 10, 10);
    check("long_press_operand", 32'(operand), 32'h0007);
    check("long_press_count", 32'(digit_count), 32'd1);
    press(4'hD, 6, 6);

    // bounce shorter than D never accepts
    bcd_key = 4'h5;
    key_read = 1'b1; tick(3);
    key_read = 1'b0; tick(1);
    key_read = 1'b1; tick(3);
    key_read = 1'b0; tick(6);
    check("bounce_operand", 32'(operand), 32'h0);
    check("bounce_count", 32'(digit_count), 32'd0);

    // fill past capacity, then backspace
    ovf_seen = 0;
    for (int d = 1; d <= 5; d++) press(4'(d), 6, 6);
    check("full_operand", 32'(operand), 32'h1234);
    check("full_count", 32'(digit_count), 32'd4);
    check("overflow_pulses", 32'(ovf_seen), 32'd1);
    press(4'hF, 6, 6);
    check("bksp_operand", 32'(operand), 32'h0123);
    check("bksp_count", 32'(digit_count), 32'd3);
    press(4'hD, 6, 6);

    // pending entry holds and discards other keys until acked
    press(4'h4, 6, 6);
    press(4'h2, 6, 6);
    press(4'hA, 6, 6);
    check("entry_valid", 32'(entry_valid), 32'h1);
    check("entry_operand", 32'(operand), 32'h0042);
    check("entry_op", 32'(op_code), 32'hA);
    press(4'h9, 6, 6);
    tick(8);
    check("held_operand", 32'(operand), 32'h0042);
    check("held_valid", 32'(entry_valid), 32'h1);
    ack_pulse();
    check("ack_valid", 32'(entry_valid), 32'h0);
    check("ack_operand", 32'(operand), 32'h0);
    check("ack_count", 32'(digit_count), 32'd0);
    check("ack_op_kept", 32'(op_code), 32'hA);

    // clear cancels a pending entry
    press(4'h8, 6, 6);
    press(4'hE, 6, 6);
    check("eq_valid", 32'(entry_valid), 32'h1);
    press(4'hD, 6, 6);
    check("clr_valid", 32'(entry_valid), 32'h0);
    check("clr_operand", 32'(operand), 32'h0);
    check("clr_op", 32'(op_code), 32'h0);
    check("clr_count", 32'(digit_count), 32'd0);

    // reset mid-debounce with key held: full debounce needed afterwards
    bcd_key = 4'h3;
    key_read = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_operand", 32'(operand), 32'h0);
    tick(3);
    check("rst_not_yet", 32'(digit_count), 32'd0);
    tick(1);
    check("rst_accepted", 32'(digit_count), 32'd1);
    check("rst_operand_3", 32'(operand), 32'h0003);
    key_read = 1'b0;
    tick(6);

    // random traffic with bounces, random acks and rare resets
    for (int t = 0; t < 400; t++) begin
      bcd_key = 4'($urandom_range(0, 15));
      entry_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 60) == 0);
      key_read = 1'b1;
      tick($urandom_range(1, 7));
      if ($urandom_range(0, 4) == 0) bcd_key = 4'($urandom_range(0, 15));
      entry_ack = 1'b0;
      rst = 1'b0;
      key_read = 1'b0;
      tick($urandom_range(1, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_entry_buffer.md
KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable cycles needed to accept a press or a release (range 1..255).
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the operand capacity in BCD digits (range 1..7).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-005 BCDKey  input  4  SHALL carry the key code from the keyboard scanner.
REQ-006 KeyRead  input  1  SHALL indicate a key is currently pressed (level).
REQ-007 EntryAck  input  1  SHALL be the consumer's acknowledge of a pending entry.
REQ-008 Operand  output  4*NUM_DIGITS  SHALL hold the accumulated BCD digits; least significant digit in bits [3:0].
REQ-009 DigitCount  output  3  SHALL hold the number of digits entered (0..NUM_DIGITS).
REQ-010 OpCode  output  4  SHALL hold the key code of the operator that completed the entry.
REQ-011 EntryValid  output  1  SHALL flag a completed entry (Operand + OpCode) awaiting EntryAck.
REQ-012 Overflow  output  1  SHALL pulse one cycle when a digit is rejected because the buffer is full.

Function
REQ-013 Key map SHALL be: 0x0-0x9 digits; 0xA add; 0xB subtract; 0xC multiply; 0xE equals; 0xD clear; 0xF backspace.
REQ-014 FSM SHALL have states IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-015 IDLE: KeyRead=1 SHALL go to PRESS_DB, latch BCDKey as candidate, load stability counter with 1.
REQ-016 PRESS_DB: KeyRead=0 or BCDKey differing from candidate SHALL return to IDLE; otherwise counter increments each cycle.
REQ-017 PRESS_DB: when counter reaches DEBOUNCE_CYCLES with inputs still matching, the key SHALL be accepted in that cycle and FSM goes to HELD.
REQ-018 HELD: KeyRead=0 SHALL go to RELEASE_DB with counter=1; any KeyRead=1 or BCDKey change SHALL be ignored.
REQ-019 RELEASE_DB: KeyRead=1 SHALL return to HELD; counter reaching DEBOUNCE_CYCLES with KeyRead=0 SHALL go to IDLE.
REQ-020 Exactly one accepted key event SHALL occur per debounced press, regardless of hold duration.
REQ-021 Accepted digit with DigitCount<NUM_DIGITS: Operand SHALL shift left 4 bits inserting the digit at [3:0]; DigitCount increments; visible the cycle after acceptance.
REQ-022 Accepted digit with DigitCount=NUM_DIGITS: Operand and DigitCount SHALL be unchanged and Overflow SHALL be 1 for exactly the next cycle.
REQ-023 Backspace: Operand SHALL shift right 4 bits (zero fill) and DigitCount decrements; at DigitCount=0 no change.
REQ-024 Clear: Operand, DigitCount, OpCode SHALL go to 0 and EntryValid to 0, also cancelling any pending entry.
REQ-025 Operator (0xA, 0xB, 0xC, 0xE) with EntryValid=0: OpCode SHALL latch the code and EntryValid SHALL assert the next cycle; Operand/DigitCount frozen.
REQ-026 EntryValid SHALL remain 1 with Operand and OpCode stable until a cycle with EntryAck=1.
REQ-027 EntryAck=1 while EntryValid=1 SHALL, the next cycle, set EntryValid=0, Operand=0, DigitCount=0; OpCode retains its value.
REQ-028 EntryAck while EntryValid=0 SHALL have no effect.
REQ-029 While EntryValid=1, accepted digit, backspace and operator keys SHALL be discarded with no output change; only clear acts.
REQ-030 Accepted clear in the same cycle as EntryAck SHALL resolve as clear (all outputs zero).
REQ-031 Debounce FSM SHALL keep running while EntryValid=1 so every press still needs a debounced release.

Reset
REQ-032 RESET=1 at a rising edge SHALL set FSM=IDLE, counter=0, Operand=0, DigitCount=0, OpCode=0, EntryValid=0, Overflow=0, with priority over all other inputs.
REQ-033 RESET mid-debounce or mid-hold SHALL drop the in-progress key; a still-held key SHALL require a fresh full debounce after RESET falls.

Verification
REQ-034 DEBOUNCE_CYCLES=4: hold key 0x7 for 10 cycles then release 10 cycles -> exactly one digit accepted, Operand=0x0007, DigitCount=1.
REQ-035 KeyRead high 3 cycles, low 1, high 3 (key 0x5) -> no acceptance, Operand=0, DigitCount=0.
REQ-036 Enter 1,2,3,4,5 (NUM_DIGITS=4) -> Operand=0x1234, DigitCount=4, one Overflow pulse on fifth digit; then backspace -> Operand=0x0123, DigitCount=3.
REQ-037 Enter 4,2 then 0xA -> EntryValid=1, Operand=0x0042, OpCode=0xA held 20 cycles; press 0x9 meanwhile -> discarded; EntryAck pulse -> EntryValid=0, Operand=0, DigitCount=0.
REQ-038 Enter 8, press 0xE, then press 0xD before EntryAck -> EntryValid=0, Operand=0, OpCode=0, DigitCount=0.
REQ-039 Assert RESET during PRESS_DB of key 0x3 with KeyRead held -> all outputs 0; after RESET falls, digit 0x3 accepted only after DEBOUNCE_CYCLES further cycles.
